// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer between the UART deserialiser and the host bus.
//   The deserialiser pushes one byte per write strobe. The host pops bytes
//   first-word-fall-through: the head byte is always presented on host_dout
//   while host_dor=1, and a host_rd strobe advances to the next entry.
//   All registers update on the falling edge of clk, the same edge the
//   receiver uses. Reset is synchronous and active-high on that edge.
//
// Ports
//   clk          clock (falling-edge active)
//   reset        synchronous active-high reset
//   din/we       byte and write strobe from the deserialiser
//   dir          at least one entry free
//   host_rd      host pop strobe
//   host_dout    head-of-queue byte, valid while host_dor=1
//   host_dor     at least one entry held
//   level        current occupancy, 0..DEPTH
//   dropped      sticky: a write arrived while full
//   clr_dropped  clears dropped (a same-cycle rejected write wins)
module uart_rx_fifo #(
    parameter int DEPTH  = 4,
    parameter int AWIDTH = 2,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] din,
    input  logic              we,
    output logic              dir,
    input  logic              host_rd,
    output logic [DWIDTH-1:0] host_dout,
    output logic              host_dor,
    output logic [AWIDTH:0]   level,
    output logic              dropped,
    input  logic              clr_dropped
);

    localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q,  count_d;
    logic              dropped_q, dropped_d;

    logic wr_acc;
    logic rd_acc;

    // Acceptance uses the pre-edge count, so at full a simultaneous read wins
    // and the write is rejected; at empty the write wins and the read is ignored.
    always_comb begin
        wr_acc    = we      && (count_q != FULL_CNT);
        rd_acc    = host_rd && (count_q != '0);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dropped_d = dropped_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

        if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
        else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

        // Set has priority over clear so a lost byte is never hidden.
        if (we && !wr_acc)    dropped_d = 1'b1;
        else if (clr_dropped) dropped_d = 1'b0;
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    // Storage is deliberately not reset; pointers define what is valid.
    always_ff @(negedge clk) begin
        if (!reset && wr_acc) mem_q[wr_ptr_q] <= din;
    end

    // Flags decode only from registered count: no path from we/host_rd.
    assign dir       = (count_q != FULL_CNT);
    assign host_dor  = (count_q != '0);
    assign level     = count_q;
    assign dropped   = dropped_q;
    assign host_dout = mem_q[rd_ptr_q];

endmodule
